mux_arb_nxw: RTL and testbench

//  Parametrised N-channel, W-bit multiplexer with registered output and valid/ready handshake.

---
 rtl/mux_arb_nxw_pkg.sv | 11 +
 rtl/mux_arb_nxw_arb.sv | 59 +++++
 rtl/mux_arb_nxw.sv | 67 ++++++
 tb/tb_mux_arb_nxw.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_nxw_pkg.sv
// Shared constants for the N-channel arbitrated mux.
package mux_arb_nxw_pkg;

  localparam int MODE_MANUAL = 0;
  localparam int MODE_PRIO   = 1;
  localparam int MODE_RR     = 2;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

endpackage

// File: rtl/mux_arb_nxw_arb.sv
// Combinational channel picker: manual, fixed-priority or round-robin.
module arb_rr_nx
  import mux_arb_nxw_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  input  logic [1:0]          mode,
  input  logic [SEL_W-1:0]    sel,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx,
  output logic                grant_vld
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    case (int'(mode))
      MODE_MANUAL: begin
        // Comparing against k keeps an out-of-range sel from indexing req.
        for (int k = 0; k < CHANNELS; k++) begin
          if (!grant_vld && k == int'(sel) && req[k]) begin
            grant_vld = 1'b1;
            grant_idx = SEL_W'(k);
            grant[k]  = 1'b1;
          end
        end
      end
      MODE_PRIO: begin
        for (int k = 0; k < CHANNELS; k++) begin
          if (!grant_vld && req[k]) begin
            grant_vld = 1'b1;
            grant_idx = SEL_W'(k);
            grant[k]  = 1'b1;
          end
        end
      end
      MODE_RR: begin
        for (int k = 0; k < CHANNELS; k++) begin
          idx = int'(ptr) + k;
          if (idx >= CHANNELS) idx = idx - CHANNELS;
          if (!grant_vld && req[idx]) begin
            grant_vld   = 1'b1;
            grant_idx   = SEL_W'(idx);
            grant[idx]  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mux_arb_nxw.sv
// N-channel, W-bit mux with registered output and valid/ready handshake.
module mux_arb_nxw
  import mux_arb_nxw_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int MODE     = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [0:0]          state;
  logic [SEL_W-1:0]    rr_ptr;
  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    grant_idx;
  logic                grant_vld;
  logic                load_en;
  logic                take;

  arb_rr_nx #(
    .CHANNELS(CHANNELS),
    .SEL_W   (SEL_W)
  ) u_arb (
    .req      (in_valid),
    .ptr      (rr_ptr),
    .mode     (2'(MODE)),
    .sel      (sel),
    .grant    (grant),
    .grant_idx(grant_idx),
    .grant_vld(grant_vld)
  );

  assign out_valid = (state == ST_FULL);
  assign load_en   = !out_valid || out_ready;
  assign take      = load_en && grant_vld;
  assign in_ready  = take ? grant : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_EMPTY;
      out_data <= '0;
      out_chan <= '0;
      rr_ptr   <= '0;
    end else if (take) begin
      state    <= ST_FULL;
      out_data <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
      out_chan <= grant_idx;
      if (MODE == MODE_RR) begin
        rr_ptr <= (grant_idx == SEL_W'(CHANNELS-1)) ? '0
                                                    : grant_idx + 1'b1;
      end
    end else if (out_valid && out_ready) begin
      state <= ST_EMPTY;
    end
  end

endmodule

// File: tb/tb_mux_arb_nxw.sv
// Bench for mux_arb_nxw: four instances (manual, priority, rr, wide rr).
module tb_mux_arb_nxw;

  localparam int NI = 4;
  localparam int NCH[NI] = '{4, 4, 4, 8};
  localparam int WID[NI] = '{8, 8, 8, 16};
  localparam int MD[NI]  = '{0, 1, 2, 2};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [127:0] din[NI];
  logic [7:0]   vin[NI];
  logic [2:0]   sl[NI];
  logic         ordy[NI];

  logic [7:0]  ir[NI];
  logic [15:0] od[NI];
  logic [2:0]  oc[NI];
  logic        ov[NI];

  logic [3:0]  ir0, ir1, ir2;
  logic [7:0]  ir3;
  logic [7:0]  od0, od1, od2;
  logic [15:0] od3;
  logic [1:0]  oc0, oc1, oc2;
  logic [2:0]  oc3;
  logic        ov0, ov1, ov2, ov3;

  mux_arb_nxw #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .MODE(0)) u0 (
    .clk(clk), .reset(rst), .in_data(din[0][31:0]),
    .in_valid(vin[0][3:0]), .in_ready(ir0), .sel(sl[0][1:0]),
    .out_data(od0), .out_chan(oc0), .out_valid(ov0),
    .out_ready(ordy[0]));

  mux_arb_nxw #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .MODE(1)) u1 (
    .clk(clk), .reset(rst), .in_data(din[1][31:0]),
    .in_valid(vin[1][3:0]), .in_ready(ir1), .sel(sl[1][1:0]),
    .out_data(od1), .out_chan(oc1), .out_valid(ov1),
    .out_ready(ordy[1]));

  mux_arb_nxw #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .MODE(2)) u2 (
    .clk(clk), .reset(rst), .in_data(din[2][31:0]),
    .in_valid(vin[2][3:0]), .in_ready(ir2), .sel(sl[2][1:0]),
    .out_data(od2), .out_chan(oc2), .out_valid(ov2),
    .out_ready(ordy[2]));

  mux_arb_nxw #(.WIDTH(16), .CHANNELS(8), .SEL_W(3), .MODE(2)) u3 (
    .clk(clk), .reset(rst), .in_data(din[3]),
    .in_valid(vin[3]), .in_ready(ir3), .sel(sl[3]),
    .out_data(od3), .out_chan(oc3), .out_valid(ov3),
    .out_ready(ordy[3]));

  always_comb begin
    ir[0] = {4'b0, ir0};
    ir[1] = {4'b0, ir1};
    ir[2] = {4'b0, ir2};
    ir[3] = ir3;
    od[0] = {8'b0, od0};
    od[1] = {8'b0, od1};
    od[2] = {8'b0, od2};
    od[3] = od3;
    oc[0] = {1'b0, oc0};
    oc[1] = {1'b0, oc1};
    oc[2] = {1'b0, oc2};
    oc[3] = oc3;
    ov[0] = ov0;
    ov[1] = ov1;
    ov[2] = ov2;
    ov[3] = ov3;
  end

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask

  // Reference model: state of each output register and rr pointer.
  logic        m_v[NI];
  logic [15:0] m_d[NI];
  int          m_c[NI];
  int          m_p[NI];

  function automatic int pick(int i, logic [7:0] v, int s, int p);
    int n;
    int k;
    n = NCH[i];
    if (MD[i] == 0) return (s < n && v[s]) ? s : -1;
    for (int j = 0; j < n; j++) begin
      k = (MD[i] == 1) ? j : (p + j) % n;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [7:0] exp_ready(int i);
    int g;
    g = pick(i, vin[i], int'(sl[i]), m_p[i]);
    if ((!m_v[i] || ordy[i]) && g >= 0) return 8'(1 << g);
    return 8'h0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        m_v[i] <= 1'b0;
        m_d[i] <= '0;
        m_c[i] <= 0;
        m_p[i] <= 0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        int g;
        logic [127:0] sh;
        g = pick(i, vin[i], int'(sl[i]), m_p[i]);
        if ((!m_v[i] || ordy[i]) && g >= 0) begin
          sh = din[i] >> (g * WID[i]);
          m_v[i] <= 1'b1;
          m_d[i] <= (WID[i] == 8) ? {8'h00, sh[7:0]} : sh[15:0];
          m_c[i] <= g;
          if (MD[i] == 2) m_p[i] <= (g + 1) % NCH[i];
        end else if (m_v[i] && ordy[i]) begin
          m_v[i] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("m_ov%0d", i), 32'(ov[i]), 32'(m_v[i]));
        chk($sformatf("m_od%0d", i), 32'(od[i]), 32'(m_d[i]));
        chk($sformatf("m_oc%0d", i), 32'(oc[i]), 32'(m_c[i]));
        chk($sformatf("m_ir%0d", i), 32'(ir[i]), 32'(exp_ready(i)));
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      din[i]  = '0;
      vin[i]  = '0;
      sl[i]   = '0;
      ordy[i] = 1'b1;
    end
    #1 rst = 1'b1;
    #11 rst = 1'b0;
    step();
    chk("rst_ov2", 32'(ov2), 0);
    chk("rst_od3", 32'(od3), 0);
    chk("rst_oc3", 32'(oc3), 0);

    // Round-robin with all four requesting.
    din[2][31:0] = 32'h13121110;
    vin[2] = 8'h0F;
    #1;
    chk("rr_ir_first", 32'(ir2), 32'h1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("rr_chan%0d", k), 32'(oc2), 32'(k % 4));
      chk($sformatf("rr_data%0d", k), 32'(od2), 32'(8'h10 + k % 4));
      chk($sformatf("rr_ir%0d", k), 32'(ir2), 32'(1 << ((k + 1) % 4)));
    end
    vin[2] = 8'h0;

    // Fixed priority.
    din[1][15:8]  = 8'hA1;
    din[1][31:24] = 8'hC3;
    vin[1] = 8'b1010;
    step();
    chk("prio_d1", 32'(od1), 32'hA1);
    chk("prio_c1", 32'(oc1), 1);
    vin[1] = 8'b1000;
    step();
    chk("prio_d3", 32'(od1), 32'hC3);
    chk("prio_c3", 32'(oc1), 3);

    // Stall.
    din[1][7:0] = 8'h55;
    vin[1] = 8'b0001;
    step();
    chk("stall_load", 32'(od1), 32'h55);
    ordy[1] = 1'b0;
    din[1][7:0] = 8'h66;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stall_d%0d", k), 32'(od1), 32'h55);
      chk($sformatf("stall_ir%0d", k), 32'(ir1), 0);
      chk($sformatf("stall_ov%0d", k), 32'(ov1), 1);
    end
    ordy[1] = 1'b1;
    #1;
    chk("stall_release_ir", 32'(ir1), 1);
    step();
    chk("stall_new", 32'(od1), 32'h66);
    vin[1] = 8'h0;
    step();
    chk("drain_ov", 32'(ov1), 0);
    chk("drain_keep", 32'(od1), 32'h66);

    // Manual select.
    sl[0] = 3'd2;
    vin[0] = 8'b0001;
    step();
    chk("man_nogrant_ov", 32'(ov0), 0);
    chk("man_nogrant_ir", 32'(ir0), 0);
    din[0][23:16] = 8'h7E;
    vin[0] = 8'b0101;
    step();
    chk("man_d", 32'(od0), 32'h7E);
    chk("man_c", 32'(oc0), 2);
    vin[0] = 8'h0;

    // Wide instance: pointer wrap.
    din[3][127:112] = 16'hBEEF;
    vin[3] = 8'h80;
    step();
    chk("wrap_c7", 32'(oc3), 7);
    chk("wrap_d7", 32'(od3), 32'hBEEF);
    chk("wrap_ptr0", 32'(u3.rr_ptr), 0);
    din[3][15:0] = 16'h1234;
    vin[3] = 8'h01;
    step();
    chk("wrap_c0", 32'(oc3), 0);
    chk("wrap_d0", 32'(od3), 32'h1234);
    chk("wrap_ptr1", 32'(u3.rr_ptr), 1);
    vin[3] = 8'h0;

    // Async reset while full.
    ordy[2] = 1'b0;
    vin[2] = 8'h0F;
    step();
    chk("pre_rst_ov", 32'(ov2), 1);
    #2 rst = 1'b1;
    vin[2] = 8'h0;
    #1;
    chk("async_ov", 32'(ov2), 0);
    chk("async_od", 32'(od2), 0);
    chk("async_oc", 32'(oc2), 0);
    #5 rst = 1'b0;
    ordy[2] = 1'b1;
    step();
    chk("post_rst_ptr", 32'(u2.rr_ptr), 0);
    chk("post_rst_ov", 32'(ov2), 0);

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
